// File: rtl/axi_read_arbiter_if.sv
// axi4_interface: AXI4 master/slave signal bundle; the arbiter only uses the read channels.
interface axi4_interface;
    logic        m_arvalid;
    logic [31:0] m_aradr;
    logic [7:0]  m_arlen;
    logic        m_rready;
    logic        s_arready;
    logic        s_rvalid;
    logic [31:0] s_rdata;
    logic        m_awvalid;
    logic        m_wvalid;
    logic        m_bready;
    modport master (
        output m_arvalid, m_aradr, m_arlen, m_rready, m_awvalid, m_wvalid, m_bready,
        input  s_arready, s_rvalid, s_rdata
    );
    modport slave (
        input  m_arvalid, m_aradr, m_arlen, m_rready, m_awvalid, m_wvalid, m_bready,
        output s_arready, s_rvalid, s_rdata
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: round-robin sharing of one AXI4 read slave, one outstanding burst at a time.
// Define AXI_READ_ARB_STATS_EN to add the grant_count and busy_cycles statistics ports.
module axi_read_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int INDEX_WIDTH = $clog2(NUM_MASTERS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_MASTERS-1:0]    req_arvalid,
    input  logic [NUM_MASTERS*32-1:0] req_aradr,
    input  logic [NUM_MASTERS*8-1:0]  req_arlen,
    output logic [NUM_MASTERS-1:0]    req_arready,
    input  logic [NUM_MASTERS-1:0]    req_rready,
    output logic [NUM_MASTERS-1:0]    req_rvalid,
    output logic [31:0]               req_rdata,
    output logic [NUM_MASTERS-1:0]    req_rlast,
`ifdef AXI_READ_ARB_STATS_EN
    output logic [NUM_MASTERS*32-1:0] grant_count,
    output logic [31:0]               busy_cycles,
`endif
    axi4_interface.master             axi_bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d, winner;
    logic [31:0]            adr_q, adr_d;
    logic [7:0]             len_q, len_d;
    logic [8:0]             beat_count_q, beat_count_d;
    logic [INDEX_WIDTH:0]   cand;
    logic                   found;
    // Round-robin search: the pending requester closest to rr_ptr (wrapping) wins.
    always_comb begin
        found = 1'b0;
        winner = rr_ptr_q;
        cand = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (INDEX_WIDTH+1)'(k);
            cand = cand >= (INDEX_WIDTH+1)'(NUM_MASTERS) ? cand - (INDEX_WIDTH+1)'(NUM_MASTERS) : cand;
            if (req_arvalid[cand[INDEX_WIDTH-1:0]]) begin
                found = 1'b1;
                winner = cand[INDEX_WIDTH-1:0];
            end
        end
    end
    // Next state and routing; the R path is purely combinational while in DATA.
    always_comb begin
        state_d = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d = owner_q;
        adr_d = adr_q;
        len_d = len_q;
        beat_count_d = beat_count_q;
        req_arready = '0;
        req_rvalid = '0;
        req_rlast = '0;
        req_rdata = '0;
        axi_bus.m_arvalid = 1'b0;
        axi_bus.m_rready = 1'b0;
        case (state_q)
            IDLE: if (found && !reset) begin
                req_arready[winner] = 1'b1;
                owner_d = winner;
                state_d = ADDR;
                for (int m = 0; m < NUM_MASTERS; m++) begin
                    if (INDEX_WIDTH'(m) == winner) begin
                        adr_d = req_aradr[m*32 +: 32];
                        len_d = req_arlen[m*8 +: 8];
                    end
                end
            end
            ADDR: begin
                axi_bus.m_arvalid = 1'b1;
                if (axi_bus.s_arready) begin
                    beat_count_d = {1'b0, len_q} + 9'd1;
                    state_d = DATA;
                end
            end
            DATA: begin
                req_rvalid[owner_q] = axi_bus.s_rvalid;
                req_rdata = axi_bus.s_rdata;
                axi_bus.m_rready = req_rready[owner_q];
                req_rlast[owner_q] = axi_bus.s_rvalid && beat_count_q == 9'd1;
                if (axi_bus.s_rvalid && req_rready[owner_q]) begin
                    beat_count_d = beat_count_q - 9'd1;
                    if (beat_count_q == 9'd1) begin
                        state_d = IDLE;
                        rr_ptr_d = owner_q == INDEX_WIDTH'(NUM_MASTERS - 1) ? '0 : owner_q + INDEX_WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign axi_bus.m_aradr = adr_q;
    assign axi_bus.m_arlen = len_q;
    assign axi_bus.m_awvalid = 1'b0;
    assign axi_bus.m_wvalid = 1'b0;
    assign axi_bus.m_bready = 1'b1;
    // Arbiter state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rr_ptr_q <= '0;
            owner_q <= '0;
            adr_q <= '0;
            len_q <= '0;
            beat_count_q <= '0;
        end else begin
            state_q <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q <= owner_d;
            adr_q <= adr_d;
            len_q <= len_d;
            beat_count_q <= beat_count_d;
        end
    end
`ifdef AXI_READ_ARB_STATS_EN
    logic [31:0] grant_count_q [NUM_MASTERS];
    logic [31:0] grant_count_d [NUM_MASTERS];
    logic [31:0] busy_cycles_q, busy_cycles_d;
    // A req_arready pulse is exactly one grant; busy counts every non-IDLE cycle.
    always_comb begin
        busy_cycles_d = busy_cycles_q + 32'(state_q != IDLE);
        for (int m = 0; m < NUM_MASTERS; m++) begin
            grant_count_d[m] = grant_count_q[m] + 32'(req_arready[m]);
            grant_count[m*32 +: 32] = grant_count_q[m];
        end
    end
    // Statistics counters, wrapping at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cycles_q <= '0;
            for (int m = 0; m < NUM_MASTERS; m++) grant_count_q[m] <= '0;
        end else begin
            busy_cycles_q <= busy_cycles_d;
            for (int m = 0; m < NUM_MASTERS; m++) grant_count_q[m] <= grant_count_d[m];
        end
    end
    assign busy_cycles = busy_cycles_q;
`endif
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed self-checking bench for axi_read_arbiter with three requesters.
module tb_axi_read_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_arvalid, req_arready, req_rready, req_rvalid, req_rlast;
    logic [95:0] req_aradr;
    logic [23:0] req_arlen;
    logic [31:0] req_rdata;
`ifdef AXI_READ_ARB_STATS_EN
    logic [95:0] grant_count;
    logic [31:0] busy_cycles;
`endif
    int checks = 0;
    int failures = 0;
    int got;
    logic [4:0] bp = 5'b11001;
    axi4_interface bus ();
    axi_read_arbiter #(.NUM_MASTERS(3)) dut (
        .clk(clk),
        .reset(reset),
        .req_arvalid(req_arvalid),
        .req_aradr(req_aradr),
        .req_arlen(req_arlen),
        .req_arready(req_arready),
        .req_rready(req_rready),
        .req_rvalid(req_rvalid),
        .req_rdata(req_rdata),
        .req_rlast(req_rlast),
`ifdef AXI_READ_ARB_STATS_EN
        .grant_count(grant_count),
        .busy_cycles(busy_cycles),
`endif
        .axi_bus(bus)
    );
    always #5 clk = ~clk;
    initial begin
        #50000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // Entered with the request already presented in IDLE; leaves the DUT in DATA at posedge+1.
    task automatic grant(input int m, input logic [31:0] adr, input logic [7:0] len, input int stall);
        #1;
        chk("arready_grant", req_arready, 96'(1) << m);
        @(posedge clk); #1;
        chk("arready_addr", req_arready, 0);
        chk("m_arvalid", bus.m_arvalid, 1);
        chk("m_aradr", bus.m_aradr, adr);
        chk("m_arlen", bus.m_arlen, len);
        bus.s_rvalid = 1'b1;
        #1;
        chk("rvalid_outside_data", req_rvalid, 0);
        bus.s_rvalid = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("m_arvalid_hold", bus.m_arvalid, 1);
            chk("m_aradr_hold", bus.m_aradr, adr);
        end
        bus.s_arready = 1'b1;
        @(posedge clk); #1;
        bus.s_arready = 1'b0;
    endtask
    // Streams len+1 beats with ready always high, then confirms the DUT left DATA.
    task automatic beats(input int m, input int len, input logic [31:0] base);
        req_rready = 3'b111;
        for (int b = 0; b <= len; b++) begin
            bus.s_rvalid = 1'b1;
            bus.s_rdata = base + 32'(b);
            #1;
            chk("rvalid", req_rvalid, 96'(1) << m);
            chk("rdata", req_rdata, base + 32'(b));
            chk("rlast", req_rlast, b == len ? 96'(1) << m : 96'(0));
            chk("m_rready", bus.m_rready, 1);
            chk("arready_data", req_arready, 0);
            @(posedge clk); #1;
        end
        #1;
        chk("rvalid_after_burst", req_rvalid, 0);
        bus.s_rvalid = 1'b0;
    endtask
    initial begin
        reset = 1'b1;
        req_arvalid = 3'b001;
        req_aradr = '0;
        req_arlen = '0;
        req_rready = '0;
        bus.s_arready = 1'b0;
        bus.s_rvalid = 1'b0;
        bus.s_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        chk("rst_arready", req_arready, 0);
        chk("rst_rvalid", req_rvalid, 0);
        chk("rst_rlast", req_rlast, 0);
        chk("rst_rdata", req_rdata, 0);
        chk("rst_m_arvalid", bus.m_arvalid, 0);
        chk("rst_m_rready", bus.m_rready, 0);
        chk("m_awvalid", bus.m_awvalid, 0);
        chk("m_wvalid", bus.m_wvalid, 0);
        chk("m_bready", bus.m_bready, 1);
        req_arvalid = '0;
        reset = 1'b0;
        // Single burst from req 0, with two stall cycles in ADDR.
        req_arvalid = 3'b001;
        req_aradr[31:0] = 32'h100;
        req_arlen[7:0] = 8'd3;
        grant(0, 32'h100, 8'd3, 2);
        req_arvalid = '0;
        beats(0, 3, 32'h10);
        // Sole request from req 2 brings rr_ptr back to 0 via the wrap.
        req_arvalid = 3'b100;
        req_aradr[95:64] = 32'h180;
        req_arlen[23:16] = 8'd1;
        grant(2, 32'h180, 8'd1, 0);
        req_arvalid = '0;
        beats(2, 1, 32'h20);
        // Contention between req 0 and req 1: grants alternate 0,1,0,1.
        req_arvalid = 3'b011;
        req_aradr[31:0] = 32'h200;
        req_aradr[63:32] = 32'h300;
        req_arlen = '0;
        grant(0, 32'h200, 8'd0, 0);
        beats(0, 0, 32'hA0);
        grant(1, 32'h300, 8'd0, 0);
        beats(1, 0, 32'hB0);
        grant(0, 32'h200, 8'd0, 0);
        beats(0, 0, 32'hA1);
        grant(1, 32'h300, 8'd0, 0);
        beats(1, 0, 32'hB1);
        req_arvalid = '0;
        // Backpressure on req 0 while the other ready bits stay high.
        req_arvalid = 3'b001;
        req_aradr[31:0] = 32'h400;
        req_arlen[7:0] = 8'd2;
        grant(0, 32'h400, 8'd2, 0);
        req_arvalid = '0;
        got = 0;
        for (int c = 0; c < 5; c++) begin
            req_rready = {2'b11, bp[c]};
            bus.s_rvalid = 1'b1;
            bus.s_rdata = 32'h40 + 32'(got);
            #1;
            chk("bp_m_rready", bus.m_rready, 96'(bp[c]));
            chk("bp_rvalid", req_rvalid, 3'b001);
            chk("bp_rdata", req_rdata, 32'h40 + 32'(got));
            chk("bp_rlast", req_rlast, got == 2 ? 3'b001 : 3'b000);
            if (req_rvalid[0] && req_rready[0]) got++;
            @(posedge clk); #1;
        end
        #1;
        chk("bp_rvalid_after", req_rvalid, 0);
        bus.s_rvalid = 1'b0;
        chk("bp_beats", 96'(got), 3);
        // Maximum length burst from req 1.
        req_arvalid = 3'b010;
        req_aradr[63:32] = 32'h800;
        req_arlen[15:8] = 8'd255;
        grant(1, 32'h800, 8'd255, 0);
        req_arvalid = '0;
        beats(1, 255, 32'h1000);
        // Reset during beat 2 of a 4-beat burst; rr_ptr was 2 before it.
        req_arvalid = 3'b001;
        req_aradr[31:0] = 32'h500;
        req_arlen[7:0] = 8'd3;
        grant(0, 32'h500, 8'd3, 0);
        req_arvalid = 3'b110;
        req_aradr[63:32] = 32'h600;
        req_aradr[95:64] = 32'h700;
        req_arlen = '0;
        req_rready = 3'b111;
        bus.s_rvalid = 1'b1;
        bus.s_rdata = 32'h50;
        #1;
        chk("mid_beat1", req_rvalid, 3'b001);
        @(posedge clk); #1;
        bus.s_rdata = 32'h51;
        #1;
        chk("mid_beat2", req_rvalid, 3'b001);
        reset = 1'b1;
        #1;
        chk("mid_rst_arready", req_arready, 0);
        chk("mid_rst_rvalid", req_rvalid, 0);
        chk("mid_rst_rlast", req_rlast, 0);
        chk("mid_rst_rdata", req_rdata, 0);
        chk("mid_rst_m_arvalid", bus.m_arvalid, 0);
        chk("mid_rst_m_rready", bus.m_rready, 0);
        bus.s_rvalid = 1'b0;
        reset = 1'b0;
        grant(1, 32'h600, 8'd0, 0);
        req_arvalid = '0;
        beats(1, 0, 32'h60);
`ifdef AXI_READ_ARB_STATS_EN
        // Statistics: 3 bursts to req 0 then 2 to req 1, each 1 ADDR + 1 DATA cycle.
        reset = 1'b1;
        #1;
        chk("stats_rst_busy", busy_cycles, 0);
        chk("stats_rst_grants", grant_count, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        req_arlen = '0;
        for (int i = 0; i < 5; i++) begin
            req_arvalid = i < 3 ? 3'b001 : 3'b010;
            grant(i < 3 ? 0 : 1, i < 3 ? 32'h600 : 32'h700, 8'd0, 0);
            req_arvalid = '0;
            beats(i < 3 ? 0 : 1, 0, 32'h90);
        end
        chk("stats_grants", grant_count, {32'd0, 32'd2, 32'd3});
        chk("stats_busy", busy_cycles, 32'd10);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
